// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared types and helpers for the common data bus producer
//
// Purpose: ROB tag type, the broadcast packet seen by reservation stations,
// map table and reorder buffer, and an index-width helper.
package cdb_arbiter_pkg;

  localparam int ROB_TAG_W = 3;   // 8 ROB entries
  localparam int CDB_XLEN  = 32;  // value width carried on the bus

  typedef logic [ROB_TAG_W-1:0] ROB_TAG;

  // Validity travels only in .valid; tag 0 is a real ROB entry.
  typedef struct packed {
    logic                valid;
    ROB_TAG              tag;
    logic [CDB_XLEN-1:0] value;
  } CDB_PACKET;

  // Width of an index into n entries, at least one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - functional-unit completion and CDB broadcast bundle
//
// Purpose: groups the FU completion handshake, squash and the registered
// broadcast outputs.
// Modports:
//   master - functional units / pipeline control: drive fu_valid, fu_tag,
//            fu_value, squash; observe fu_ready, cdb_packet, cdb_fu_idx.
//   slave  - the arbiter: the reverse directions.
interface cdb_arbiter_if #(
  parameter int NUM_FU = 5,
  parameter int XLEN   = 32
);
  import cdb_arbiter_pkg::*;

  localparam int IDX_W = idx_width(NUM_FU);

  logic [NUM_FU-1:0]            fu_valid;
  ROB_TAG [NUM_FU-1:0]          fu_tag;
  logic [NUM_FU-1:0][XLEN-1:0]  fu_value;
  logic [NUM_FU-1:0]            fu_ready;
  logic                         squash;
  CDB_PACKET                    cdb_packet;
  logic [IDX_W-1:0]             cdb_fu_idx;

  modport master (
    output fu_valid, fu_tag, fu_value, squash,
    input  fu_ready, cdb_packet, cdb_fu_idx
  );

  modport slave (
    input  fu_valid, fu_tag, fu_value, squash,
    output fu_ready, cdb_packet, cdb_fu_idx
  );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rtl/cdb_arbiter_rr_arbiter.sv - combinational round-robin selector
//
// Purpose: picks the first set request scanning upward from ptr, wrapping
// modulo N. Purely combinational so it can be reused for issue selection.
// Ports:
//   req       in  [N]  request vector
//   ptr       in       scan start index (expected < N)
//   grant     out [N]  one-hot grant, zero when no request
//   grant_idx out      index of the granted request (0 when none)
//   grant_any out      at least one request was granted
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int N  = 5,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  // One spare bit so ptr+off can exceed N-1 before the wrap subtraction.
  logic [IW:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int off = 0; off < N; off++) begin
      idx = {1'b0, ptr} + (IW+1)'(off);
      if (idx >= (IW+1)'(N)) begin
        idx = idx - (IW+1)'(N);
      end
      if (!grant_any && req[idx[IW-1:0]]) begin
        grant[idx[IW-1:0]] = 1'b1;
        grant_idx          = idx[IW-1:0];
        grant_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin producer of the common data bus
//
// Purpose: one holding register per functional unit; each cycle one held
// result is granted round-robin and broadcast as a registered CDB_PACKET.
// Ports:
//   clock  in  rising-edge clock
//   reset  in  asynchronous, active-high
//   bus    slave modport of cdb_arbiter_if:
//            fu_valid/fu_tag/fu_value in, fu_ready out (FU handshake)
//            squash in (flush pending and outgoing results)
//            cdb_packet, cdb_fu_idx out (registered broadcast)
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = 5,
  parameter int XLEN   = CDB_XLEN
) (
  input logic          clock,
  input logic          reset,
  cdb_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_FU);

  logic [NUM_FU-1:0]           hold_valid_q, hold_valid_d;
  ROB_TAG [NUM_FU-1:0]         hold_tag_q, hold_tag_d;
  logic [NUM_FU-1:0][XLEN-1:0] hold_value_q, hold_value_d;
  logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
  CDB_PACKET                   cdb_packet_q, cdb_packet_d;
  logic [IDX_W-1:0]            cdb_fu_idx_q, cdb_fu_idx_d;

  logic [NUM_FU-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;
  logic [NUM_FU-1:0] fu_ready;
  logic [NUM_FU-1:0] accept;

  rr_arbiter #(
    .N (NUM_FU)
  ) u_rr_arbiter (
    .req       (hold_valid_q),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // A slot being granted this cycle can take a new result on the same edge,
  // so a single uncontested FU streams one result per cycle. fu_ready never
  // looks at fu_valid.
  assign fu_ready = bus.squash ? '0 : (~hold_valid_q | grant);
  assign accept   = bus.fu_valid & fu_ready;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_tag_d   = hold_tag_q;
    hold_value_d = hold_value_q;
    rr_ptr_d     = rr_ptr_q;
    cdb_packet_d = '0;
    cdb_fu_idx_d = '0;

    if (bus.squash) begin
      // Flush wins over everything; pointer keeps its fairness position.
      hold_valid_d = '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept[i]) begin
          hold_valid_d[i] = 1'b1;
          hold_tag_d[i]   = bus.fu_tag[i];
          hold_value_d[i] = bus.fu_value[i];
        end else if (grant[i]) begin
          hold_valid_d[i] = 1'b0;
        end
      end

      if (grant_any) begin
        cdb_packet_d.valid = 1'b1;
        cdb_packet_d.tag   = hold_tag_q[grant_idx];
        cdb_packet_d.value = hold_value_q[grant_idx];
        cdb_fu_idx_d       = grant_idx;
        rr_ptr_d = (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid_q <= '0;
      hold_tag_q   <= '0;
      hold_value_q <= '0;
      rr_ptr_q     <= '0;
      cdb_packet_q <= '0;
      cdb_fu_idx_q <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_tag_q   <= hold_tag_d;
      hold_value_q <= hold_value_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_packet_q <= cdb_packet_d;
      cdb_fu_idx_q <= cdb_fu_idx_d;
    end
  end

  assign bus.fu_ready   = fu_ready;
  assign bus.cdb_packet = cdb_packet_q;
  assign bus.cdb_fu_idx = cdb_fu_idx_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cdb_arbiter_if #(.NUM_FU(5), .XLEN(32)) bus ();

  cdb_arbiter #(.NUM_FU(5), .XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  valid;
    logic [14:0] tags;
    logic        squash;
    logic [4:0]  exp_ready;
    logic        exp_v;
    logic [2:0]  exp_tag;
    logic [2:0]  exp_idx;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] val_of(input int i, input logic [2:0] t);
    return 32'hC0DE_0000 | (32'(i) << 8) | 32'(t);
  endfunction

  function automatic logic [14:0] tg(input int t4, input int t3, input int t2,
                                     input int t1, input int t0);
    return {3'(t4), 3'(t3), 3'(t2), 3'(t1), 3'(t0)};
  endfunction

  function automatic void add(input logic [4:0] v, input logic [14:0] tags,
                              input logic sq, input logic [4:0] rdy,
                              input logic ev, input int et, input int ei);
    vec_t r;
    r.valid     = v;
    r.tags      = tags;
    r.squash    = sq;
    r.exp_ready = rdy;
    r.exp_v     = ev;
    r.exp_tag   = 3'(et);
    r.exp_idx   = 3'(ei);
    vecs.push_back(r);
  endfunction

  task automatic drive(input logic [4:0] v, input logic [14:0] tags, input logic sq);
    bus.fu_valid = v;
    bus.squash   = sq;
    for (int i = 0; i < 5; i++) begin
      bus.fu_tag[i]   = tags[i*3 +: 3];
      bus.fu_value[i] = val_of(i, tags[i*3 +: 3]);
    end
  endtask

  task automatic chk_rdy(input string nm, input logic [4:0] exp);
    total++;
    if (bus.fu_ready !== exp) begin
      bad++;
      $display("FAIL %s: fu_ready got %b want %b", nm, bus.fu_ready, exp);
    end
  endtask

  task automatic chk_pkt(input string nm, input logic v, input logic [2:0] t,
                         input logic [31:0] val, input logic [2:0] idx);
    total++;
    if (bus.cdb_packet.valid !== v || bus.cdb_packet.tag !== t ||
        bus.cdb_packet.value !== val || bus.cdb_fu_idx !== idx) begin
      bad++;
      $display("FAIL %s: got v=%0b tag=%0d value=%h idx=%0d, want v=%0b tag=%0d value=%h idx=%0d",
               nm, bus.cdb_packet.valid, bus.cdb_packet.tag, bus.cdb_packet.value,
               bus.cdb_fu_idx, v, t, val, idx);
    end
  endtask

  initial begin
    // contention: FU0,1,3 at once from rr_ptr=0, ends with rr_ptr=4
    add(5'b01011, tg(0,3,0,2,1), 0, 5'b11111, 0, 0, 0);
    add(5'b00000, tg(0,0,0,0,0), 0, 5'b10101, 1, 1, 0);
    add(5'b00000, tg(0,0,0,0,0), 0, 5'b10111, 1, 2, 1);
    add(5'b00000, tg(0,0,0,0,0), 0, 5'b11111, 1, 3, 3);
    // fairness: FU0 and FU4 valid every cycle; FU4 first proves rr_ptr=4
    add(5'b10001, tg(6,0,0,0,4), 0, 5'b11111, 0, 0, 0);
    add(5'b10001, tg(1,0,0,0,2), 0, 5'b11110, 1, 6, 4);
    add(5'b10001, tg(3,0,0,0,2), 0, 5'b01111, 1, 4, 0);
    add(5'b10001, tg(3,0,0,0,7), 0, 5'b11110, 1, 1, 4);
    add(5'b10001, tg(5,0,0,0,7), 0, 5'b01111, 1, 2, 0);
    add(5'b10001, tg(5,0,0,0,0), 0, 5'b11110, 1, 3, 4);
    add(5'b00001, tg(0,0,0,0,0), 0, 5'b01111, 1, 7, 0);
    add(5'b00000, tg(0,0,0,0,0), 0, 5'b11110, 1, 5, 4);
    add(5'b00000, tg(0,0,0,0,0), 0, 5'b11111, 1, 0, 0);
    add(5'b00000, tg(0,0,0,0,0), 0, 5'b11111, 0, 0, 0);
    // back-pressure: move rr_ptr to 3, then FU0 beats FU1, FU1 second result
    add(5'b00100, tg(0,0,1,0,0), 0, 5'b11111, 0, 0, 0);
    add(5'b00000, tg(0,0,0,0,0), 0, 5'b11111, 1, 1, 2);
    add(5'b00011, tg(0,0,0,4,2), 0, 5'b11111, 0, 0, 0);
    add(5'b00010, tg(0,0,0,6,0), 0, 5'b11101, 1, 2, 0);
    add(5'b00010, tg(0,0,0,6,0), 0, 5'b11111, 1, 4, 1);
    add(5'b00000, tg(0,0,0,0,0), 0, 5'b11111, 1, 6, 1);
    add(5'b00000, tg(0,0,0,0,0), 0, 5'b11111, 0, 0, 0);
    // squash: FU0/FU2 pending, squash refuses an FU2 offer, then FU2 again
    add(5'b00101, tg(0,0,5,0,3), 0, 5'b11111, 0, 0, 0);
    add(5'b00100, tg(0,0,1,0,0), 1, 5'b00000, 0, 0, 0);
    add(5'b00000, tg(0,0,0,0,0), 0, 5'b11111, 0, 0, 0);
    add(5'b00100, tg(0,0,7,0,0), 0, 5'b11111, 0, 0, 0);
    add(5'b00000, tg(0,0,0,0,0), 0, 5'b11111, 1, 7, 2);

    // reset state
    drive(5'b00000, 15'd0, 1'b0);
    #1;
    chk_rdy("reset ready", 5'b11111);
    chk_pkt("reset pkt", 1'b0, 3'd0, 32'd0, 3'd0);
    @(posedge clock); #1;
    chk_pkt("reset pkt held", 1'b0, 3'd0, 32'd0, 3'd0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[r]) begin
      @(negedge clock);
      drive(vecs[r].valid, vecs[r].tags, vecs[r].squash);
      #1;
      chk_rdy($sformatf("row%0d ready", r), vecs[r].exp_ready);
      @(posedge clock); #1;
      chk_pkt($sformatf("row%0d pkt", r), vecs[r].exp_v, vecs[r].exp_tag,
              vecs[r].exp_v ? val_of(int'(vecs[r].exp_idx), vecs[r].exp_tag) : 32'd0,
              vecs[r].exp_idx);
    end

    // single FU with a full-width value, one-cycle offer
    @(negedge clock);
    drive(5'b00000, 15'd0, 1'b0);
    bus.fu_valid    = 5'b00100;
    bus.fu_tag[2]   = 3'd5;
    bus.fu_value[2] = 32'hDEAD_BEEF;
    #1;
    chk_rdy("single ready", 5'b11111);
    @(posedge clock); #1;
    chk_pkt("single load", 1'b0, 3'd0, 32'd0, 3'd0);
    @(negedge clock);
    drive(5'b00000, 15'd0, 1'b0);
    @(posedge clock); #1;
    chk_pkt("single bcast", 1'b1, 3'd5, 32'hDEAD_BEEF, 3'd2);
    @(posedge clock); #1;
    chk_pkt("single idle", 1'b0, 3'd0, 32'd0, 3'd0);

    // reset mid-burst (rr_ptr=3 here)
    @(negedge clock);
    drive(5'b01011, tg(0,3,0,2,1), 1'b0);
    @(posedge clock); #1;
    chk_pkt("burst load", 1'b0, 3'd0, 32'd0, 3'd0);
    @(negedge clock);
    drive(5'b00100, tg(0,0,4,0,0), 1'b0);
    #1;
    chk_rdy("burst ready", 5'b11100);
    @(posedge clock); #1;
    chk_pkt("burst bcast", 1'b1, 3'd3, val_of(3, 3'd3), 3'd3);
    #2;
    reset = 1'b1;
    drive(5'b00000, 15'd0, 1'b0);
    #1;
    chk_pkt("async reset pkt", 1'b0, 3'd0, 32'd0, 3'd0);
    chk_rdy("async reset ready", 5'b11111);
    @(posedge clock); #1;
    chk_rdy("reset held ready", 5'b11111);
    @(negedge clock);
    reset = 1'b0;
    drive(5'b11000, tg(6,7,0,0,0), 1'b0);
    #1;
    chk_rdy("post reset ready", 5'b11111);
    @(posedge clock); #1;
    chk_pkt("post reset load", 1'b0, 3'd0, 32'd0, 3'd0);
    @(negedge clock);
    drive(5'b00000, 15'd0, 1'b0);
    @(posedge clock); #1;
    chk_pkt("post reset fu3", 1'b1, 3'd7, val_of(3, 3'd7), 3'd3);
    @(posedge clock); #1;
    chk_pkt("post reset fu4", 1'b1, 3'd6, val_of(4, 3'd6), 3'd4);
    @(posedge clock); #1;
    chk_pkt("post reset idle", 1'b0, 3'd0, 32'd0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
